// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared state/grant encodings for the unified-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

  function automatic int wait_cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Brief  : Core fetch/data ports and memory port of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module : mem_arb_pick
// Brief  : Data-first winner selection with fetch starvation guard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  arb_en,
  input  wire  ei,
  input  wire  ed,
  output gnt_t gnt
);

  localparam int WCW = wait_cnt_w(MAX_WAIT);
  localparam logic [WCW-1:0] CNT_MAX = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] CNT_ONE = WCW'(1);

  logic [WCW-1:0] wait_cnt_q;
  logic [WCW-1:0] wait_cnt_d;

  always_comb begin
    gnt = GNT_NONE;
    if (arb_en) begin
      if (ei && ed) begin
        gnt = (wait_cnt_q == CNT_MAX) ? GNT_I : GNT_D;
      end else if (ei) begin
        gnt = GNT_I;
      end else if (ed) begin
        gnt = GNT_D;
      end
    end

    // Only a data win that actually made fetch wait counts as a loss.
    wait_cnt_d = wait_cnt_q;
    if (gnt == GNT_I) begin
      wait_cnt_d = '0;
    end else if (gnt == GNT_D && ei && wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one single-port memory between fetch and data ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  wire              clk,
  input  wire              reset,
  mem_arbiter_if.slave     bus,
  output logic             busy
);

  state_t        state_q,     state_d;
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_done_q,    i_done_d;
  logic          d_done_q,    d_done_d;
  logic [DW-1:0] i_rdata_q,   i_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;

  logic ei;
  logic ed;
  gnt_t gnt;

  // A requester still seeing its done pulse must not be granted again.
  assign ei = bus.i_req & ~i_done_q;
  assign ed = bus.d_req & ~d_done_q;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .arb_en (state_q == IDLE),
    .ei     (ei),
    .ed     (ed),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        case (gnt)
          GNT_I: begin
            state_d     = BUSY_I;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
          end
          GNT_D: begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end
          default: ;
        endcase
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = bus.mem_rdata;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed vector bench for mem_arbiter with a small memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    int          lat;
    bit          exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wc;
    int          cyc;
  } gnt_rec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_dly = 2;
  int i_done_cnt = 0;
  int d_done_cnt = 0;
  gnt_rec_t glog[$];
  int ack_cyc[$];
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.i_done) i_done_cnt = i_done_cnt + 1;
    if (bus.d_done) d_done_cnt = d_done_cnt + 1;
  end

  // Memory model: logs each new request, acks after ack_dly sampled cycles.
  initial begin
    int rcnt;
    rcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.mem_ack = 1'b0;
        rcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        rcnt = 0;
      end else if (bus.mem_req) begin
        if (rcnt == 0)
          glog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata,
                           int'(dut.u_pick.wait_cnt_q), cyc});
        rcnt++;
        if (rcnt >= ack_dly) begin
          bus.mem_ack = 1'b1;
          ack_cyc.push_back(cyc);
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = 32'hBAD0_BAD0;
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
          end
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    bit seen;
    int g0, id0, dd0;
    ack_dly = v.dly;
    g0 = glog.size();
    id0 = i_done_cnt;
    dd0 = d_done_cnt;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr; bus.d_wdata = 32'h5555_AAAA;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      n++;
      seen = v.is_d ? bus.d_done : bus.i_done;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_latency", idx), {seen, 32'(n)}, {1'b1, 32'(v.lat)});
    chk($sformatf("v%0d_grant_count", idx), 96'(glog.size()), 96'(g0 + 1));
    if (glog.size() > g0)
      chk($sformatf("v%0d_mem_bus", idx),
          {glog[g0].we, glog[g0].addr, glog[g0].wdata}, {v.exp_we, v.addr, v.exp_wdata});
    chk($sformatf("v%0d_done_pulses", idx), {32'(i_done_cnt - id0), 32'(d_done_cnt - dd0)},
        v.is_d ? {32'd0, 32'd1} : {32'd1, 32'd0});
    chk($sformatf("v%0d_rdata", idx), v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t vt[7];
    int g0, a0, dd0, n;
    bit idn, ddn, raise;

    vt[0] = '{0, 0, 32'h10, 32'h0,        2, 3, 0, 32'h0,        32'hE3A0_0005};
    vt[1] = '{1, 1, 32'h64, 32'h7,        2, 3, 1, 32'h7,        32'h0};
    vt[2] = '{1, 0, 32'h64, 32'h0,        1, 2, 0, 32'h0,        32'h7};
    vt[3] = '{0, 0, 32'h20, 32'h0,        3, 4, 0, 32'h0,        32'h1234_5678};
    vt[4] = '{1, 1, 32'h80, 32'hDEADBEEF, 1, 2, 1, 32'hDEADBEEF, 32'h7};
    vt[5] = '{1, 0, 32'h80, 32'h0,        4, 5, 0, 32'h0,        32'hDEADBEEF};
    vt[6] = '{0, 0, 32'h64, 32'h0,        1, 2, 0, 32'h0,        32'h7};

    mem[32'h10] = 32'hE3A0_0005;
    mem[32'h20] = 32'h1234_5678;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_done, bus.d_done, busy},
        '0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_rdata_waitcnt", {bus.i_rdata, bus.d_rdata, 32'(dut.u_pick.wait_cnt_q)}, '0);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Simultaneous: data first, fetch granted in the d_done cycle.
    g0 = glog.size(); a0 = ack_cyc.size();
    ack_dly = 2;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_wdata = 32'h0;
    idn = 1'b0; ddn = 1'b0; n = 0;
    while (!(idn && ddn) && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.d_done) begin ddn = 1'b1; bus.d_req = 1'b0; end
      if (bus.i_done) begin idn = 1'b1; bus.i_req = 1'b0; end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sim_both_done", {idn, ddn}, 2'b11);
    chk("sim_grant_count", 96'(glog.size()), 96'(g0 + 2));
    if (glog.size() >= g0 + 2 && ack_cyc.size() > a0) begin
      chk("sim_first_data", {glog[g0].we, glog[g0].addr, 32'(glog[g0].wc)}, {1'b0, 32'h80, 32'd1});
      chk("sim_then_fetch", {glog[g0+1].we, glog[g0+1].addr, 32'(glog[g0+1].wc)}, {1'b0, 32'h20, 32'd0});
      chk("sim_req_gap", 96'(glog[g0+1].cyc - ack_cyc[a0]), 96'd2);
    end
    chk("sim_rdata", {bus.i_rdata, bus.d_rdata}, {32'h1234_5678, 32'hDEADBEEF});

    // Starvation guard: fetch drops only during d_done cycles so data keeps winning.
    g0 = glog.size(); dd0 = d_done_cnt;
    ack_dly = 1;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_wdata = 32'h0;
    idn = 1'b0; raise = 1'b0; n = 0;
    while (!idn && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (raise) begin bus.i_req = 1'b1; raise = 1'b0; end
      if (bus.d_done) begin bus.d_addr = bus.d_addr + 32'd4; bus.i_req = 1'b0; raise = 1'b1; end
      if (bus.i_done) begin idn = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0; end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("starve_grant_count", {1'b0 ^ idn, 32'(glog.size())}, {1'b1, 32'(g0 + 5)});
    chk("starve_data_dones", 96'(d_done_cnt - dd0), 96'd4);
    for (int k = 0; k < 4; k++) begin
      if (glog.size() > g0 + k)
        chk($sformatf("starve_data%0d", k), {glog[g0+k].we, glog[g0+k].addr, 32'(glog[g0+k].wc)},
            {1'b0, 32'h100 + 32'(4 * k), 32'(k + 1)});
    end
    if (glog.size() > g0 + 4)
      chk("starve_fetch", {glog[g0+4].we, glog[g0+4].addr, 32'(glog[g0+4].wc)}, {1'b0, 32'h10, 32'd0});

    // Async reset in the middle of a store.
    dd0 = d_done_cnt;
    ack_dly = 6;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h99;
    n = 0;
    while (!bus.mem_req && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #2;
    chk("rst_busy_before", {bus.mem_req, busy}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rst_async", {bus.mem_req, busy}, 2'b00);
    bus.d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_done", 96'(d_done_cnt - dd0), 96'd0);
    run_vec(7, '{0, 0, 32'h10, 32'h0, 1, 2, 0, 32'h0, 32'hE3A0_0005});

    // i_req held one cycle past i_done must not re-issue.
    g0 = glog.size();
    ack_dly = 1;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    n = 0;
    while (!bus.i_done && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("nodup_cycle1", {bus.mem_req, busy}, 2'b00);
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    chk("nodup_cycle2", {bus.mem_req, busy}, 2'b00);
    chk("nodup_grants", 96'(glog.size()), 96'(g0 + 1));
    chk("nodup_rdata", bus.i_rdata, 32'h1234_5678);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
